// File: rtl/agc_gain_apply.sv
// agc_gain_apply: slews the applied AGC gain toward a registered target and scales I/Q samples with rounding and saturation
module agc_gain_apply #(
  parameter int          GAIN_FRAC     = 8,
  parameter int          MAX_STEP      = 64,
  parameter int          UPDATE_PERIOD = 16,
  parameter logic [23:0] GAIN_MAX      = 24'h00FFFF
) (
  input  logic               clk,
  input  logic               arst,
  input  logic signed [15:0] data_in_I,
  input  logic signed [15:0] data_in_Q,
  input  logic               data_in_valid,
  input  logic        [23:0] gain,
  input  logic               gain_valid,
  input  logic               hold,
  input  logic               sat_clr,
  output logic signed [15:0] data_out_I,
  output logic signed [15:0] data_out_Q,
  output logic               data_out_valid,
  output logic               sat_flag,
  output logic        [23:0] gain_applied,
  output logic        [15:0] sat_count
);
  localparam int                 CW       = UPDATE_PERIOD > 1 ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic        [23:0] UNITY    = 24'(1) << GAIN_FRAC;
  localparam logic        [23:0] STEP     = 24'(MAX_STEP);
  localparam logic     [CW-1:0] CNT_LAST = CW'(UPDATE_PERIOD - 1);
  localparam logic signed [40:0] HALF     = 41'sd1 <<< (GAIN_FRAC - 1);
  localparam logic signed [40:0] SMAX     = 41'sd32767;
  localparam logic signed [40:0] SMIN     = -41'sd32768;
  logic        [23:0] target, applied, gain_clip, diff, applied_nxt;
  logic     [CW-1:0] cnt;
  logic               up, step;
  logic signed [15:0] s1_i, s1_q;
  logic        [23:0] s1_g;
  logic               s1_v, s2_v;
  logic signed [40:0] p_i, p_q, r_i, r_q;
  logic signed [15:0] y_i, y_q;
  logic               c_i, c_q;
  assign gain_applied = applied;
  always_comb begin
    gain_clip   = gain > GAIN_MAX ? GAIN_MAX : gain;
    up          = target >= applied;
    diff        = up ? target - applied : applied - target;
    applied_nxt = diff <= STEP ? target : up ? applied + STEP : applied - STEP;
    step        = data_in_valid && !hold && cnt == CNT_LAST;
    r_i         = (p_i + HALF) >>> GAIN_FRAC;
    r_q         = (p_q + HALF) >>> GAIN_FRAC;
    c_i         = r_i > SMAX || r_i < SMIN;
    c_q         = r_q > SMAX || r_q < SMIN;
    y_i         = r_i > SMAX ? 16'sh7FFF : r_i < SMIN ? 16'sh8000 : r_i[15:0];
    y_q         = r_q > SMAX ? 16'sh7FFF : r_q < SMIN ? 16'sh8000 : r_q[15:0];
  end
  // the sample register captures applied before any step on the same edge, so it uses the pre-step gain
  always_ff @(posedge clk) begin
    if (arst) begin
      target         <= UNITY;
      applied        <= UNITY;
      cnt            <= '0;
      s1_v           <= 1'b0;
      s2_v           <= 1'b0;
      data_out_I     <= '0;
      data_out_Q     <= '0;
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
      sat_count      <= '0;
    end else begin
      if (gain_valid) target <= gain_clip;
      if (data_in_valid && !hold) cnt <= step ? '0 : cnt + CW'(1);
      if (step) applied <= applied_nxt;
      s1_v <= data_in_valid;
      if (data_in_valid) begin
        s1_i <= data_in_I;
        s1_q <= data_in_Q;
        s1_g <= applied;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        p_i <= s1_i * $signed({1'b0, s1_g});
        p_q <= s1_q * $signed({1'b0, s1_g});
      end
      data_out_valid <= s2_v;
      if (s2_v) begin
        data_out_I <= y_i;
        data_out_Q <= y_q;
        sat_flag   <= c_i || c_q;
      end
      sat_count <= sat_clr ? '0 : (s2_v && (c_i || c_q) && sat_count != 16'hFFFF) ? sat_count + 16'd1 : sat_count;
    end
  end
endmodule
